vital_sample_averager: RTL
==========================

Name: vital_sample_averager

Overview:
- Sequential front-end stage that accumulates a fixed window of 8-bit vital-sign samples and produces a rounded window average.
- Flags high/low alarms on that average.
- Sits directly upstream of the 8-bit adder datapath and the alarm logic: its average and alarm outputs are the operands those blocks consume.
- Ready/valid handshake on both the sample input and the result output.

Parameters:
- DATA_W, 8: sample and average width in bits.
- LOG2_N, 3: log2 of window length (window N = 8 samples).
- HI_THRESH, 8'd120: alarm_hi asserts when average > HI_THRESH.
- LO_THRESH, 8'd50: alarm_lo asserts when average < LO_THRESH.
- Derived, not overridable: ACC_W = DATA_W + LOG2_N + 1 (12 bits at defaults).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- clear  input  1  synchronous window abort, active-high.
- in_valid  input  1  in_data holds a valid sample.
- in_data  input  DATA_W  sample value, unsigned.
- in_ready  output  1  block accepts a sample this cycle.
- avg_valid  output  1  avg_data and alarms hold a valid result.
- avg_ready  input  1  downstream accepts the result.
- avg_data  output  DATA_W  rounded window average, unsigned.
- alarm_hi  output  1  registered with avg_data; avg_data > HI_THRESH.
- alarm_lo  output  1  registered with avg_data; avg_data < LO_THRESH.
- sample_cnt  output  LOG2_N  samples accepted in the current window.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=ACCUM; acc=0; sample_cnt=0.
  - avg_valid=0, avg_data=0, alarm_hi=0, alarm_lo=0.
  - Applies from any state, including mid-window and mid-RESULT.
- clear=1 (with rst_n=1):
  - Same effect as reset, except avg_data is unchanged.
  - A sample presented in the same cycle is discarded.
  - A pending result is dropped.
- Priority: rst_n > clear > handshakes.
- States: ACCUM, RESULT.
- ACCUM:
  - in_ready=1 and avg_valid=0.
  - A sample is accepted when in_valid && in_ready: acc += in_data and sample_cnt increments.
  - When the accepted sample is the Nth (sample_cnt == N-1), the next edge loads avg_data = (acc + in_data + 2^(LOG2_N-1)) >> LOG2_N (round half-up), loads both alarms from that value, sets avg_valid=1, and enters RESULT.
  - acc and sample_cnt are zeroed on that same edge.
- RESULT:
  - in_ready=0; in_valid is ignored and no sample is lost or counted.
  - avg_valid=1. avg_data and the alarms are held stable until transfer.
  - When avg_valid && avg_ready, the next edge sets avg_valid=0 and returns to ACCUM.
  - in_ready rises the cycle after the transfer. There is no same-cycle bypass.
- Latency: 1 cycle from the Nth accept to avg_valid.
- Throughput: one window per N+1 cycles minimum with avg_ready held high.
- in_ready is a combinational decode of state only; it does not depend on in_valid. avg_valid is a registered output.
- Arithmetic:
  - acc is unsigned and ACC_W wide, so it never overflows.
  - The maximum rounded result is (2040+4)>>3 = 255. avg_data must still saturate to 2^DATA_W-1 if the shifted value exceeds it (parameter safety).
- Alarms are mutually exclusive by construction when LO_THRESH <= HI_THRESH.
- Alarms keep their last result value after transfer. They clear only on reset or clear.
- in_data is don't-care when in_valid=0. X on in_data must not corrupt acc.

Test Plan:
- Reset, then 8 samples of 100 back-to-back with avg_ready=1:
  - avg_valid pulses 1 cycle after the 8th accept; avg_data=100; alarm_hi=0, alarm_lo=0.
  - in_ready=0 for exactly 1 cycle.
- Rounding and low alarm:
  - Samples 0..7 (sum 28) -> avg_data=4, alarm_lo=1.
  - Samples {4,1,1,1,1,1,1,1} (sum 11) -> avg_data=1.
  - Samples {5,1,1,1,1,1,1,1} (sum 12) -> avg_data=2.
- Full scale: 8 samples of 255 -> avg_data=255, alarm_hi=1, alarm_lo=0, acc has no wrap.
- Backpressure:
  - After a window of 130 (alarm_hi=1), hold avg_ready=0 for 5 cycles while driving in_valid=1, in_data=0.
  - Required: avg_valid, avg_data=130 and alarm_hi stay stable; in_ready=0; sample_cnt=0.
  - Raise avg_ready: transfer occurs, then the next window counts only samples accepted after in_ready returns.
- Clear mid-window: accept 5 samples of 200, assert clear for 1 cycle, then send 8 samples of 60.
  - Required: sample_cnt=0 after the clear; avg_data=60; no result is produced for the aborted window.
- Reset mid-RESULT: with avg_valid=1 and avg_ready=0, drive rst_n=0 for 1 edge.
  - Required: avg_valid=0, avg_data=0, both alarms 0, in_ready=1 the cycle after reset is released.

Source files
------------

// File: rtl/vital_sample_averager.sv
// Windowed averager for 8-bit vital-sign samples: sums N samples, emits a
// rounded average with high/low alarms over a ready/valid result port.
module vital_sample_averager #(
  parameter int                DATA_W    = 8,
  parameter int                LOG2_N    = 3,
  parameter logic [DATA_W-1:0] HI_THRESH = 8'd120,
  parameter logic [DATA_W-1:0] LO_THRESH = 8'd50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              avg_valid,
  input  logic              avg_ready,
  output logic [DATA_W-1:0] avg_data,
  output logic              alarm_hi,
  output logic              alarm_lo,
  output logic [LOG2_N-1:0] sample_cnt
);

  localparam int ACC_W = DATA_W + LOG2_N + 1;
  // Half of the window length; written as a shift pair so LOG2_N = 0 gives 0.
  localparam logic [ACC_W-1:0] ROUND_C = ACC_W'((1 << LOG2_N) >> 1);
  localparam logic [ACC_W-1:0] MAX_AVG = ACC_W'((1 << DATA_W) - 1);

  typedef enum logic {
    ACCUM,
    RESULT
  } state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic              hi_q, hi_d;
  logic              lo_q, lo_d;

  logic              accept;
  logic              transfer;
  logic              last_sample;
  logic [ACC_W-1:0]  sample_ext;
  logic [ACC_W-1:0]  sum_rounded;
  logic [ACC_W-1:0]  sum_shifted;
  logic [DATA_W-1:0] avg_next;

  assign in_ready    = (state_q == ACCUM);
  assign accept      = in_valid && in_ready;
  assign transfer    = valid_q && avg_ready;
  assign last_sample = &cnt_q;

  // Sample only enters the sum through accept, so X on an idle bus never lands in acc.
  assign sample_ext  = {{(ACC_W-DATA_W){1'b0}}, in_data};
  assign sum_rounded = acc_q + sample_ext + ROUND_C;
  assign sum_shifted = sum_rounded >> LOG2_N;
  assign avg_next    = (sum_shifted > MAX_AVG) ? {DATA_W{1'b1}}
                                               : sum_shifted[DATA_W-1:0];

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through the case/if tree leaves it unassigned and infers a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    avg_d   = avg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          if (last_sample) begin
            avg_d   = avg_next;
            hi_d    = (avg_next > HI_THRESH);
            lo_d    = (avg_next < LO_THRESH);
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = RESULT;
          end else begin
            acc_d = acc_q + sample_ext;
            cnt_d = cnt_q + LOG2_N'(1);
          end
        end
      end
      RESULT: begin
        if (transfer) begin
          valid_d = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase

    // Window abort overrides any handshake; the last average stays visible.
    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
      hi_d    = 1'b0;
      lo_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      avg_q   <= '0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      avg_q   <= avg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign avg_valid  = valid_q;
  assign avg_data   = avg_q;
  assign alarm_hi   = hi_q;
  assign alarm_lo   = lo_q;
  assign sample_cnt = cnt_q;

endmodule
